// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter for instruction fetch and data access with fixed latency and fetch fairness.
// Optional hit counters (icount/dcount) are enabled by defining MEMORY_ARBITER_STATS_EN.
module memory_arbiter #(
  parameter int unsigned LAT = 2,
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          iREN,
  input  logic [AW-1:0] iaddr,
  output logic          ihit,
  output logic [DW-1:0] iload,
  input  logic          dREN,
  input  logic          dWEN,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dstore,
  output logic          dhit,
  output logic [DW-1:0] dload,
  output logic          ramREN,
  output logic          ramWEN,
  output logic [AW-1:0] ramaddr,
  output logic [DW-1:0] ramstore,
  input  logic [DW-1:0] ramload
`ifdef MEMORY_ARBITER_STATS_EN
  ,
  output logic [31:0]   icount,
  output logic [31:0]   dcount
`endif
);

  typedef enum logic [2:0] {IDLE, IBUSY, DBUSY, IRESP, DRESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ipri_q, ipri_d;
  logic          dwr_q, dwr_d;
  logic [AW-1:0] ramaddr_q, ramaddr_d;
  logic [DW-1:0] ramstore_q, ramstore_d;
  logic [DW-1:0] iload_q, iload_d;
  logic [DW-1:0] dload_q, dload_d;
  logic          dreq;

  assign dreq = dREN | dWEN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ipri_q     <= 1'b0;
      dwr_q      <= 1'b0;
      ramaddr_q  <= '0;
      ramstore_q <= '0;
      iload_q    <= '0;
      dload_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ipri_q     <= ipri_d;
      dwr_q      <= dwr_d;
      ramaddr_q  <= ramaddr_d;
      ramstore_q <= ramstore_d;
      iload_q    <= iload_d;
      dload_q    <= dload_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ipri_d     = ipri_q;
    dwr_d      = dwr_q;
    ramaddr_d  = ramaddr_q;
    ramstore_d = ramstore_q;
    iload_d    = iload_q;
    dload_d    = dload_q;
    unique case (state_q)
      IDLE: begin
        // Data wins by default; a fetch starved by a completed data access goes first.
        if (iREN && (ipri_q || !dreq)) begin
          state_d   = IBUSY;
          cnt_d     = 4'(LAT);
          ramaddr_d = iaddr;
          ipri_d    = 1'b0;
        end else if (dreq) begin
          state_d    = DBUSY;
          cnt_d      = 4'(LAT);
          ramaddr_d  = daddr;
          ramstore_d = dstore;
          dwr_d      = dWEN;
        end
      end
      IBUSY: begin
        if (cnt_q == 4'd0) begin
          iload_d = ramload;
          state_d = IRESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DBUSY: begin
        if (cnt_q == 4'd0) begin
          if (!dwr_q) dload_d = ramload;
          state_d = DRESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      IRESP: state_d = IDLE;
      DRESP: begin
        state_d = IDLE;
        if (iREN) ipri_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Hits are qualified by the live request so a dropped request completes silently.
  assign ihit     = (state_q == IRESP) && iREN;
  assign dhit     = (state_q == DRESP) && dreq;
  assign ramREN   = (state_q == IBUSY) || ((state_q == DBUSY) && !dwr_q);
  assign ramWEN   = (state_q == DBUSY) && dwr_q;
  assign ramaddr  = ramaddr_q;
  assign ramstore = ramstore_q;
  assign iload    = iload_q;
  assign dload    = dload_q;

`ifdef MEMORY_ARBITER_STATS_EN
  logic [31:0] icount_q, dcount_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icount_q <= '0;
      dcount_q <= '0;
    end else begin
      if (ihit) icount_q <= icount_q + 32'd1;
      if (dhit) dcount_q <= dcount_q + 32'd1;
    end
  end

  assign icount = icount_q;
  assign dcount = dcount_q;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter (LAT=2): expected hits are queued at stimulus and matched on output.
module tb_memory_arbiter;

  localparam int LAT = 2;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        ihit, dhit, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
`ifdef MEMORY_ARBITER_STATS_EN
  logic [31:0] icount, dcount;
  int          exp_icount = 0, exp_dcount = 0;
`endif

  typedef struct {
    bit          is_i;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] last_dload = '0;

  memory_arbiter #(.LAT(LAT), .AW(32), .DW(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload)
`ifdef MEMORY_ARBITER_STATS_EN
    , .icount(icount), .dcount(dcount)
`endif
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  function automatic logic [31:0] ram_val(input logic [31:0] a);
    return (a == 32'h40) ? 32'h12345678 : (a ^ 32'hC0DE_0000);
  endfunction

  assign ramload = ram_val(ramaddr);

  task automatic push(input bit is_i, input logic [31:0] data, input int at);
    exp_t e;
    e.is_i = is_i;
    e.data = data;
    e.cyc  = at;
    sb.push_back(e);
`ifdef MEMORY_ARBITER_STATS_EN
    if (is_i) exp_icount++; else exp_dcount++;
`endif
  endtask

  always @(negedge CLK) begin
    if (ihit || dhit) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_hit: ihit=%0b dhit=%0b at cycle %0d, required no hit", ihit, dhit, cyc);
      end else begin
        exp_t        e;
        logic [31:0] got;
        e   = sb.pop_front();
        got = e.is_i ? iload : dload;
        if (ihit !== e.is_i || dhit !== !e.is_i || cyc != e.cyc || got !== e.data) begin
          errors++;
          $display("FAIL hit_match: ihit=%0b dhit=%0b cyc=%0d load=%h, required ihit=%0b dhit=%0b cyc=%0d load=%h",
                   ihit, dhit, cyc, got, e.is_i, !e.is_i, e.cyc, e.data);
        end
      end
    end
  end

  task automatic test_reset;
    nRST = 1'b0; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1;
    iaddr = 32'h44; daddr = 32'h88; dstore = 32'h1;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({ihit, dhit, ramREN, ramWEN} !== 4'b0 || iload !== '0 || dload !== '0 ||
        ramaddr !== '0 || ramstore !== '0) begin
      errors++;
      $display("FAIL reset_outputs: hits/strobes=%b iload=%h dload=%h ramaddr=%h ramstore=%h, required all 0",
               {ihit, dhit, ramREN, ramWEN}, iload, dload, ramaddr, ramstore);
    end
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    @(posedge CLK); #1 nRST = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      checks++;
      if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset: ramREN=%b ramWEN=%b cycle %0d, required 0 0", ramREN, ramWEN, k);
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_iread;
    int n0;
    n0 = cyc;
    iREN = 1'b1; iaddr = 32'h40;
    push(1'b1, 32'h12345678, n0 + LAT + 2);
    for (int k = 0; k <= 5; k++) begin
      @(negedge CLK);
      checks++;
      if (ramREN !== (k >= 1 && k <= 3)) begin
        errors++;
        $display("FAIL iread_ramREN: ramREN=%b cycle %0d, required %b", ramREN, k, (k >= 1 && k <= 3));
      end
      if (k == 2) begin
        checks++;
        if (ramaddr !== 32'h40) begin
          errors++;
          $display("FAIL iread_addr: ramaddr=%h, required 00000040", ramaddr);
        end
      end
      @(posedge CLK); #1;
      if (k == 4) iREN = 1'b0;
    end
  endtask

  task automatic test_simultaneous;
    int n0;
    n0 = cyc;
    dREN = 1'b1; daddr = 32'h80; iREN = 1'b1; iaddr = 32'h0;
    push(1'b0, ram_val(32'h80), n0 + 4);
    push(1'b1, ram_val(32'h0), n0 + 9);
    last_dload = ram_val(32'h80);
    for (int k = 0; k <= 10; k++) begin
      @(negedge CLK);
      if (k == 1 || k == 6) begin
        checks++;
        if (ramaddr !== ((k == 1) ? 32'h80 : 32'h0)) begin
          errors++;
          $display("FAIL simul_addr: ramaddr=%h cycle %0d, required %h", ramaddr, k, (k == 1) ? 32'h80 : 32'h0);
        end
      end
      @(posedge CLK); #1;
      if (k == 4) dREN = 1'b0;
      if (k == 9) iREN = 1'b0;
    end
  endtask

  task automatic test_back_to_back;
    int          n0;
    logic [31:0] ea [4];
    n0 = cyc;
    ea[0] = 32'h300; ea[1] = 32'h200; ea[2] = 32'h304; ea[3] = 32'h204;
    iREN = 1'b1; iaddr = 32'h200; dREN = 1'b1; daddr = 32'h300;
    push(1'b0, ram_val(32'h300), n0 + 4);
    push(1'b1, ram_val(32'h200), n0 + 9);
    push(1'b0, ram_val(32'h304), n0 + 14);
    push(1'b1, ram_val(32'h204), n0 + 19);
    last_dload = ram_val(32'h304);
    for (int k = 0; k <= 20; k++) begin
      @(negedge CLK);
      if (k % 5 == 1 && k < 20) begin
        checks++;
        if (ramaddr !== ea[k / 5]) begin
          errors++;
          $display("FAIL b2b_order: ramaddr=%h grant %0d, required %h", ramaddr, k / 5, ea[k / 5]);
        end
      end
      @(posedge CLK); #1;
      if (k == 4)  daddr = 32'h304;
      if (k == 9)  iaddr = 32'h204;
      if (k == 14) daddr = 32'h308;
      if (k == 19) begin iREN = 1'b0; dREN = 1'b0; end
    end
  endtask

  task automatic test_write;
    int n0, wen_cycles;
    n0 = cyc;
    wen_cycles = 0;
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    push(1'b0, last_dload, n0 + 4);
    for (int k = 0; k <= 5; k++) begin
      @(negedge CLK);
      if (ramWEN === 1'b1) wen_cycles++;
      checks++;
      if (ramREN !== 1'b0) begin
        errors++;
        $display("FAIL write_ramREN: ramREN=%b cycle %0d, required 0", ramREN, k);
      end
      if (k == 2) begin
        checks++;
        if (ramWEN !== 1'b1 || ramstore !== 32'hDEADBEEF || ramaddr !== 32'h100) begin
          errors++;
          $display("FAIL write_bus: ramWEN=%b ramstore=%h ramaddr=%h, required 1 deadbeef 00000100",
                   ramWEN, ramstore, ramaddr);
        end
      end
      @(posedge CLK); #1;
      if (k == 4) dWEN = 1'b0;
    end
    checks++;
    if (wen_cycles != LAT + 1) begin
      errors++;
      $display("FAIL write_len: ramWEN high %0d cycles, required %0d", wen_cycles, LAT + 1);
    end
  endtask

  task automatic test_abort_reset;
    int ren_cycles;
    ren_cycles = 0;
    dREN = 1'b1; daddr = 32'h140;
    for (int k = 0; k <= 5; k++) begin
      @(negedge CLK);
      if (ramREN === 1'b1) ren_cycles++;
      if (k == 4) begin
        checks++;
        if (dhit !== 1'b0) begin
          errors++;
          $display("FAIL abort_dhit: dhit=%b, required 0", dhit);
        end
      end
      @(posedge CLK); #1;
      if (k == 1) dREN = 1'b0;
    end
    checks++;
    if (ren_cycles != LAT + 1 || dload !== ram_val(32'h140)) begin
      errors++;
      $display("FAIL abort_complete: ramREN cycles=%0d dload=%h, required %0d %h",
               ren_cycles, dload, LAT + 1, ram_val(32'h140));
    end
    iREN = 1'b1; iaddr = 32'h180;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    nRST = 1'b0;
    #1;
    checks++;
    if ({ramREN, ramWEN, ihit, dhit} !== 4'b0 || iload !== '0) begin
      errors++;
      $display("FAIL midreset: strobes/hits=%b iload=%h, required 0000 00000000",
               {ramREN, ramWEN, ihit, dhit}, iload);
    end
`ifdef MEMORY_ARBITER_STATS_EN
    exp_icount = 0; exp_dcount = 0;
`endif
    iREN = 1'b0;
    @(posedge CLK); #1 nRST = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      checks++;
      if (ramREN !== 1'b0 || ihit !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle: ramREN=%b ihit=%b cycle %0d, required 0 0", ramREN, ihit, k);
      end
    end
  endtask

  initial begin
    test_reset;
    test_iread;
    test_simultaneous;
    test_back_to_back;
    test_write;
`ifdef MEMORY_ARBITER_STATS_EN
    checks++;
    if (icount !== 32'(exp_icount) || dcount !== 32'(exp_dcount)) begin
      errors++;
      $display("FAIL stats: icount=%0d dcount=%0d, required %0d %0d", icount, dcount, exp_icount, exp_dcount);
    end
`endif
    test_abort_reset;
    repeat (2) @(negedge CLK);
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_hit: no hit seen, required is_i=%0b at cycle %0d", e.is_i, e.cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
